clusterv_tile_sram_mp_bfm: RTL and testbench
============================================

# clusterv_tile_sram_mp_bfm

Parametrised multi-port, byte-enable SRAM target model for the cluster tile bench. It serves as the next-generation tile SRAM model: N independent target ports share one storage array. Each port has a programmable read latency and a per-port read-valid strobe. The model detects same-cycle write collisions and keeps saturating access counters. It sits in `verilog/dv/common` and replaces the single-port, fixed-latency tile SRAM model wherever the tile under test exposes more than one SRAM port or a pipelined read.

## Interface
- `DAT_WIDTH`, 32: data width per port; a multiple of 8.
- `ADR_WIDTH`, 8: word-address width; depth is 2**ADR_WIDTH words.
- `N_PORTS`, 2: number of target ports, from 1 to 4.
- `RD_LATENCY`, 1: clock edges from read request to data, from 1 to 4.
- `INIT_VALUE`, 0: value loaded into every word at time zero. Reset does not apply it.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `t_req`  in  N_PORTS  per-port access enable.
- `t_write_en`  in  N_PORTS  per port: 1 selects a write, 0 selects a read (only when `t_req` is high).
- `t_addr`  in  N_PORTS*ADR_WIDTH  word address; port p occupies bits [p*ADR_WIDTH +: ADR_WIDTH].
- `t_byte_en`  in  N_PORTS*DAT_WIDTH/8  byte enables for writes; ignored on reads.
- `t_write_data`  in  N_PORTS*DAT_WIDTH  write data.
- `t_read_data`  out  N_PORTS*DAT_WIDTH  read data; holds its value between valid strobes.
- `t_read_valid`  out  N_PORTS  one-cycle strobe marking new `t_read_data` for that port.
- `collision`  out  1  one-cycle pulse: a write collision was sampled on the previous edge.
- `collision_sticky`  out  1  set by any collision; cleared only by reset.
- `wr_count`  out  32  total accepted write requests across all ports; saturates at 0xFFFFFFFF.
- `rd_count`  out  32  total accepted read requests across all ports; saturates at 0xFFFFFFFF.

## Operation
- Access accepted on a port at a rising edge when `reset`=0 and `t_req`=1.
- Write: bytes whose `t_byte_en` bit is set are written into `mem[addr]`. Other bytes are unchanged.
- Read: `mem[addr]` is sampled at the acceptance edge, read-before-write. A same-cycle write from any port to that address is not visible to the read.
- Sampled read data enters a per-port delay line `RD_LATENCY` stages deep.
- Write collision: two or more ports write the same address in the same cycle with overlapping byte enables.
  - Each overlapping byte takes the value from the highest-index port.
  - Non-overlapping bytes from all ports are written.
  - `collision` pulses and `collision_sticky` sets.
  - Writes to the same address with disjoint enables are not a collision.
- Counters add the number of accepted writes or reads each edge (0 to N_PORTS). A counter clamps at all-ones rather than wrapping.
- `t_req`=0: no memory, counter or pipeline update for that port.

## Timing
- Read accepted at edge n: `t_read_data` for that port updates and `t_read_valid` is 1 in the cycle following edge n+RD_LATENCY-1. With RD_LATENCY=1, data is visible in the cycle after the request edge.
- Back-to-back reads on one port: one result per cycle, in order, no bubbles.
- Write is visible to a read accepted at any later edge (edge n+1 onward).
- `collision` is asserted for exactly the cycle after the colliding edge.
- Reset state, at the edge where `reset`=1:
  - `t_read_data`=0, `t_read_valid`=0, `collision`=0, `collision_sticky`=0, `wr_count`=0, `rd_count`=0.
  - All delay-line valid bits are cleared; in-flight reads are dropped and never strobe.
  - Memory contents are retained.
  - Requests presented while `reset`=1 are ignored, including writes.
- First access can be accepted at the first edge with `reset`=0.
- Parameters outside their stated ranges: `$fatal` at elaboration.

## Structure
- Package `clusterv_sram_bfm_pkg` holds the shared definitions:
  - `RD_LATENCY_MAX`=4, `N_PORTS_MAX`=4, `CNT_WIDTH`=32.
  - A saturating-add function, shared with future BFMs.
- Sub-module `clusterv_sram_rd_pipe`, one instance per port:
  - Parameters `DAT_WIDTH` and `RD_LATENCY`.
  - A shift register of {valid, data} stages.
  - Output registers that hold the last valid data.
  - Synchronous reset clears only the valid bits and the output data.
- Top level holds the array, the per-byte write-merge loop (ascending port order so the highest index wins), collision compare and counters.

## Test plan
- RD_LATENCY=3, port 0:
  - Stimulus: write 0xDEADBEEF to address 0x10 with byte_en=0xF, then read 0x10 on the next cycle.
  - Response: `t_read_valid[0]` strobes 3 edges after the read with 0xDEADBEEF; `wr_count`=1, `rd_count`=1.
- Byte-enable merge:
  - Stimulus: fill 0x20 with 0x11223344, write 0xAABBCCDD with byte_en=0x5, read 0x20.
  - Response: read returns 0x11BB33DD.
- Read and write from different ports, same address, same cycle:
  - Stimulus: port 0 reads 0x30 (old value 0x0) while port 1 writes 0x55 to it.
  - Response: port 0 returns 0x0; a read at the next cycle returns 0x55; `collision` stays 0.
- Write collision:
  - Stimulus: port 0 writes 0x000000AA and port 1 writes 0x000000BB to 0x40, both with byte_en=0x1.
  - Response: memory holds 0xBB in byte 0; `collision` pulses for one cycle; `collision_sticky` remains 1.
  - Follow-up: disjoint enables (0x1 and 0x2) to the same address produce no collision.
- Reset mid-flight:
  - Stimulus: with RD_LATENCY=4, issue 4 reads, then assert `reset` for one edge.
  - Response: no `t_read_valid` ever strobes for them; all outputs are 0; earlier written data is still readable after reset.
- Saturation:
  - Stimulus: force `wr_count` to 0xFFFFFFFE, then issue 2 concurrent writes for 2 cycles.
  - Response: `wr_count` holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/clusterv_sram_bfm_pkg.sv
// Shared definitions for the cluster SRAM bus-functional models:
// parameter limits, counter width and a saturating adder.
package clusterv_sram_bfm_pkg;

  localparam int RD_LATENCY_MAX = 4;
  localparam int N_PORTS_MAX    = 4;
  localparam int CNT_WIDTH      = 32;

  // Clamps at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/clusterv_sram_rd_pipe.sv
// Per-port read delay line: RD_LATENCY stages of {valid, data}; the last data
// stage doubles as the output register and holds the last valid word.
module clusterv_sram_rd_pipe #(
  parameter int DAT_WIDTH  = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DAT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  output logic [DAT_WIDTH-1:0] out_data
);

  logic [RD_LATENCY:1]                vld_pipe;
  logic [RD_LATENCY:1][DAT_WIDTH-1:0] dat_pipe;
  // Element k is the value feeding stage k+1.
  logic [RD_LATENCY-1:0]                vld_in;
  logic [RD_LATENCY-1:0][DAT_WIDTH-1:0] dat_in;

  always_comb begin
    vld_in    = '0;
    dat_in    = '0;
    vld_in[0] = in_valid;
    dat_in[0] = in_data;
    for (int k = 1; k < RD_LATENCY; k++) begin
      vld_in[k] = vld_pipe[k];
      dat_in[k] = dat_pipe[k];
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 1; k < RD_LATENCY; k++)
      dat_pipe[k] <= dat_in[k-1];
    if (reset) begin
      vld_pipe             <= '0;
      dat_pipe[RD_LATENCY] <= '0;
    end else begin
      vld_pipe <= vld_in;
      if (vld_in[RD_LATENCY-1])
        dat_pipe[RD_LATENCY] <= dat_in[RD_LATENCY-1];
    end
  end

  assign out_valid = vld_pipe[RD_LATENCY];
  assign out_data  = dat_pipe[RD_LATENCY];

endmodule

// File: rtl/clusterv_tile_sram_mp_bfm.sv
// Multi-port byte-enable SRAM target model: shared array, per-port read
// delay lines, same-cycle write collision detect and saturating access counters.
module clusterv_tile_sram_mp_bfm
  import clusterv_sram_bfm_pkg::*;
#(
  parameter int                   DAT_WIDTH  = 32,
  parameter int                   ADR_WIDTH  = 8,
  parameter int                   N_PORTS    = 2,
  parameter int                   RD_LATENCY = 1,
  parameter logic [DAT_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N_PORTS-1:0]             t_req,
  input  logic [N_PORTS-1:0]             t_write_en,
  input  logic [N_PORTS*ADR_WIDTH-1:0]   t_addr,
  input  logic [N_PORTS*DAT_WIDTH/8-1:0] t_byte_en,
  input  logic [N_PORTS*DAT_WIDTH-1:0]   t_write_data,
  output logic [N_PORTS*DAT_WIDTH-1:0]   t_read_data,
  output logic [N_PORTS-1:0]             t_read_valid,
  output logic                           collision,
  output logic                           collision_sticky,
  output logic [CNT_WIDTH-1:0]           wr_count,
  output logic [CNT_WIDTH-1:0]           rd_count
);

  localparam int NB    = DAT_WIDTH / 8;
  localparam int DEPTH = 2 ** ADR_WIDTH;

  if (DAT_WIDTH < 8 || DAT_WIDTH % 8 != 0) begin : g_bad_dat_width
    $fatal(1, "DAT_WIDTH must be a non-zero multiple of 8");
  end
  if (N_PORTS < 1 || N_PORTS > N_PORTS_MAX) begin : g_bad_n_ports
    $fatal(1, "N_PORTS out of range");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_rd_latency
    $fatal(1, "RD_LATENCY out of range");
  end
  if (ADR_WIDTH < 1) begin : g_bad_adr_width
    $fatal(1, "ADR_WIDTH must be at least 1");
  end

  logic [N_PORTS-1:0][ADR_WIDTH-1:0] addr;
  logic [N_PORTS-1:0][NB-1:0]        byte_en;
  logic [N_PORTS-1:0][DAT_WIDTH-1:0] wdata;
  logic [N_PORTS-1:0][DAT_WIDTH-1:0] rdata_raw;
  logic [N_PORTS-1:0][DAT_WIDTH-1:0] rdata_out;

  assign addr        = t_addr;
  assign byte_en     = t_byte_en;
  assign wdata       = t_write_data;
  assign t_read_data = rdata_out;

  // Reset blocks acceptance entirely, so writes during reset are dropped.
  logic [N_PORTS-1:0] wr_acc, rd_acc;
  assign wr_acc = t_req &  t_write_en & {N_PORTS{~reset}};
  assign rd_acc = t_req & ~t_write_en & {N_PORTS{~reset}};

  logic [DAT_WIDTH-1:0] mem [DEPTH] = '{default: INIT_VALUE};

  always_comb begin
    rdata_raw = '0;
    for (int p = 0; p < N_PORTS; p++)
      rdata_raw[p] = mem[addr[p]];
  end

  // Ascending port order: later non-blocking updates win, so the highest
  // index port owns any overlapping byte.
  always_ff @(posedge clock) begin
    for (int p = 0; p < N_PORTS; p++)
      if (wr_acc[p])
        for (int b = 0; b < NB; b++)
          if (byte_en[p][b])
            mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
  end

  logic coll_now;
  always_comb begin
    coll_now = 1'b0;
    for (int p = 0; p < N_PORTS; p++)
      for (int q = p + 1; q < N_PORTS; q++)
        if (wr_acc[p] && wr_acc[q] && addr[p] == addr[q] && |(byte_en[p] & byte_en[q]))
          coll_now = 1'b1;
  end

  logic [CNT_WIDTH-1:0] n_wr, n_rd;
  always_comb begin
    n_wr = '0;
    n_rd = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      n_wr = n_wr + {{(CNT_WIDTH-1){1'b0}}, wr_acc[p]};
      n_rd = n_rd + {{(CNT_WIDTH-1){1'b0}}, rd_acc[p]};
    end
  end

  logic [CNT_WIDTH-1:0] wr_cnt, rd_cnt;
  always_ff @(posedge clock) begin
    if (reset) begin
      collision        <= 1'b0;
      collision_sticky <= 1'b0;
      wr_cnt           <= '0;
      rd_cnt           <= '0;
    end else begin
      collision        <= coll_now;
      collision_sticky <= collision_sticky | coll_now;
      wr_cnt           <= sat_add(wr_cnt, n_wr);
      rd_cnt           <= sat_add(rd_cnt, n_rd);
    end
  end

  assign wr_count = wr_cnt;
  assign rd_count = rd_cnt;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    clusterv_sram_rd_pipe #(
      .DAT_WIDTH (DAT_WIDTH),
      .RD_LATENCY(RD_LATENCY)
    ) u_rd_pipe (
      .clock    (clock),
      .reset    (reset),
      .in_valid (rd_acc[p]),
      .in_data  (rdata_raw[p]),
      .out_valid(t_read_valid[p]),
      .out_data (rdata_out[p])
    );
  end

endmodule

// File: tb/tb_clusterv_tile_sram_mp_bfm.sv
// Bench for the multi-port SRAM model: directed vectors plus random traffic
// checked every cycle against a queue-based memory/latency model.
module tb_clusterv_tile_sram_mp_bfm;
  localparam int NP = 2, AW = 8, DW = 32, LAT = 3, NB = DW / 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [NP-1:0]    t_req, t_write_en;
  logic [NP*AW-1:0] t_addr;
  logic [NP*NB-1:0] t_byte_en;
  logic [NP*DW-1:0] t_write_data;
  logic [NP*DW-1:0] t_read_data;
  logic [NP-1:0]    t_read_valid;
  logic             collision, collision_sticky;
  logic [31:0]      wr_count, rd_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  clusterv_tile_sram_mp_bfm #(
    .DAT_WIDTH(DW), .ADR_WIDTH(AW), .N_PORTS(NP), .RD_LATENCY(LAT), .INIT_VALUE('0)
  ) dut (
    .clock(clock), .reset(reset), .t_req(t_req), .t_write_en(t_write_en),
    .t_addr(t_addr), .t_byte_en(t_byte_en), .t_write_data(t_write_data),
    .t_read_data(t_read_data), .t_read_valid(t_read_valid),
    .collision(collision), .collision_sticky(collision_sticky),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  // Reference model: plain memory array plus per-port queues of reads
  // tagged with the edge number at which they must appear.
  typedef struct { longint due; logic [DW-1:0] data; } rd_t;
  logic [DW-1:0]         mmem [256];
  rd_t                   pend [NP][$];
  longint                edge_n = 0;
  logic [NP-1:0]         e_valid;
  logic [NP-1:0][DW-1:0] e_rdata;
  logic                  e_coll, e_sticky;
  logic [31:0]           e_wr, e_rd;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] init;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h edge=%0d", name, act, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    int nw, nr;
    logic coll;
    longint s;
    logic [AW-1:0] a, b2;
    edge_n++;
    if (reset) begin
      for (int p = 0; p < NP; p++) pend[p].delete();
      e_valid = '0; e_rdata = '0; e_coll = 1'b0; e_sticky = 1'b0; e_wr = '0; e_rd = '0;
      return;
    end
    nw = 0; nr = 0; coll = 1'b0;
    for (int p = 0; p < NP; p++) begin
      a = t_addr[p*AW +: AW];
      if (t_req[p] && !t_write_en[p]) begin
        pend[p].push_back('{edge_n + LAT - 1, mmem[a]});
        nr++;
      end
    end
    for (int p = 0; p < NP; p++)
      for (int q = p + 1; q < NP; q++) begin
        a  = t_addr[p*AW +: AW];
        b2 = t_addr[q*AW +: AW];
        if (t_req[p] && t_write_en[p] && t_req[q] && t_write_en[q] && a == b2 &&
            (t_byte_en[p*NB +: NB] & t_byte_en[q*NB +: NB]) != '0)
          coll = 1'b1;
      end
    for (int p = 0; p < NP; p++) begin
      a = t_addr[p*AW +: AW];
      if (t_req[p] && t_write_en[p]) begin
        nw++;
        for (int b = 0; b < NB; b++)
          if (t_byte_en[p*NB + b]) mmem[a][b*8 +: 8] = t_write_data[p*DW + b*8 +: 8];
      end
    end
    e_coll   = coll;
    e_sticky = e_sticky | coll;
    s = longint'(e_wr) + nw;
    e_wr = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
    s = longint'(e_rd) + nr;
    e_rd = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
    for (int p = 0; p < NP; p++) begin
      e_valid[p] = 1'b0;
      if (pend[p].size() > 0 && pend[p][0].due == edge_n) begin
        e_valid[p] = 1'b1;
        e_rdata[p] = pend[p].pop_front().data;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    chk("read_valid", 32'(t_read_valid), 32'(e_valid));
    for (int p = 0; p < NP; p++) chk($sformatf("read_data%0d", p), t_read_data[p*DW +: DW], e_rdata[p]);
    chk("collision", 32'(collision), 32'(e_coll));
    chk("collision_sticky", 32'(collision_sticky), 32'(e_sticky));
    chk("wr_count", wr_count, e_wr);
    chk("rd_count", rd_count, e_rd);
  endtask

  task automatic idle();
    t_req = '0; t_write_en = '0; t_addr = '0; t_byte_en = '0; t_write_data = '0;
  endtask

  task automatic setp(input int p, input logic we, input logic [7:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    t_req[p] = 1'b1; t_write_en[p] = we; t_addr[p*AW +: AW] = a;
    t_byte_en[p*NB +: NB] = be; t_write_data[p*DW +: DW] = d;
  endtask

  // Read one address on port 0 and wait until its strobe cycle.
  task automatic read0(input logic [7:0] a);
    idle(); setp(0, 1'b0, a, 4'h0, 32'h0); tick();
    idle(); repeat (LAT - 1) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    e_valid = '0; e_rdata = '0; e_coll = 1'b0; e_sticky = 1'b0; e_wr = '0; e_rd = '0;
    vt[0] = '{8'h20, 32'h11223344, 32'hAABBCCDD, 4'h5, 32'h11BB33DD};
    vt[1] = '{8'h21, 32'h11223344, 32'hAABBCCDD, 4'hA, 32'hAA22CC44};
    vt[2] = '{8'h22, 32'h11223344, 32'hAABBCCDD, 4'h0, 32'h11223344};
    vt[3] = '{8'h23, 32'h11223344, 32'hAABBCCDD, 4'hF, 32'hAABBCCDD};
    vt[4] = '{8'h24, 32'h11223344, 32'hAABBCCDD, 4'h8, 32'hAA223344};

    reset = 1'b1; idle();
    tick(); tick();
    chk("rst_valid", 32'(t_read_valid), 32'h0);
    chk("rst_data", t_read_data[31:0], 32'h0);
    chk("rst_wr_count", wr_count, 32'h0);
    reset = 1'b0;

    // Write then read, latency 3.
    setp(0, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF); tick();
    idle(); setp(0, 1'b0, 8'h10, 4'h0, 32'h0); tick();
    idle(); tick();
    chk("lat_early_valid", 32'(t_read_valid[0]), 32'h0);
    tick();
    chk("lat_valid", 32'(t_read_valid[0]), 32'h1);
    chk("lat_data", t_read_data[31:0], 32'hDEADBEEF);
    chk("lat_wr_count", wr_count, 32'd1);
    chk("lat_rd_count", rd_count, 32'd1);
    tick();
    chk("lat_hold_data", t_read_data[31:0], 32'hDEADBEEF);

    // Byte-enable merge table.
    for (int i = 0; i < 5; i++) begin
      idle(); setp(0, 1'b1, vt[i].a, 4'hF, vt[i].init); tick();
      idle(); setp(1, 1'b1, vt[i].a, vt[i].be, vt[i].wd); tick();
      read0(vt[i].a);
      chk($sformatf("merge%0d_valid", i), 32'(t_read_valid[0]), 32'h1);
      chk($sformatf("merge%0d_data", i), t_read_data[31:0], vt[i].exp);
    end

    // Read-before-write across ports.
    idle(); setp(0, 1'b0, 8'h30, 4'h0, 32'h0); setp(1, 1'b1, 8'h30, 4'hF, 32'h55); tick();
    idle(); setp(0, 1'b0, 8'h30, 4'h0, 32'h0); tick();
    idle(); tick();
    chk("rbw_old", t_read_data[31:0], 32'h0);
    chk("rbw_coll", 32'(collision), 32'h0);
    tick();
    chk("rbw_new", t_read_data[31:0], 32'h55);

    // Write collision, then disjoint enables.
    idle(); setp(0, 1'b1, 8'h40, 4'h1, 32'hAA); setp(1, 1'b1, 8'h40, 4'h1, 32'hBB); tick();
    chk("coll_pulse", 32'(collision), 32'h1);
    chk("coll_sticky", 32'(collision_sticky), 32'h1);
    idle(); tick();
    chk("coll_drop", 32'(collision), 32'h0);
    chk("coll_sticky_hold", 32'(collision_sticky), 32'h1);
    read0(8'h40);
    chk("coll_data", t_read_data[31:0], 32'h000000BB);
    idle(); setp(0, 1'b1, 8'h41, 4'h1, 32'hAA); setp(1, 1'b1, 8'h41, 4'h2, 32'hBB00); tick();
    chk("disjoint_coll", 32'(collision), 32'h0);
    read0(8'h41);
    chk("disjoint_data", t_read_data[31:0], 32'h0000BBAA);

    // Reset with reads in flight; writes during reset are ignored.
    idle(); setp(0, 1'b0, 8'h10, 4'h0, 32'h0); tick();
    idle(); setp(1, 1'b0, 8'h10, 4'h0, 32'h0); tick();
    idle(); reset = 1'b1;
    setp(0, 1'b1, 8'h10, 4'hF, 32'h12345678); setp(1, 1'b0, 8'h10, 4'h0, 32'h0); tick();
    chk("rst_flight_valid", 32'(t_read_valid), 32'h0);
    chk("rst_flight_sticky", 32'(collision_sticky), 32'h0);
    chk("rst_flight_rd_count", rd_count, 32'h0);
    reset = 1'b0; idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_strobe", 32'(t_read_valid), 32'h0);
    end
    read0(8'h10);
    chk("rst_retained", t_read_data[31:0], 32'hDEADBEEF);

    // Counter saturation.
    force dut.wr_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.wr_cnt;
    e_wr = 32'hFFFF_FFFE;
    chk("sat_preload", wr_count, 32'hFFFF_FFFE);
    idle(); setp(0, 1'b1, 8'h50, 4'hF, 32'h1); setp(1, 1'b1, 8'h51, 4'hF, 32'h2); tick();
    chk("sat_first", wr_count, 32'hFFFF_FFFF);
    tick();
    chk("sat_second", wr_count, 32'hFFFF_FFFF);

    // Random traffic on a small address window to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      idle();
      reset = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 9) < 7)
          setp(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
               4'($urandom_range(0, 15)), $urandom);
      tick();
    end
    reset = 1'b0; idle();
    repeat (LAT + 1) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
